// File: rtl/decode_stage.sv
// Decode stage of a 5-stage RV32I pipeline: 32x32 register file, immediate
// generator, main/ALU decoder and the ID/EX pipeline register.
// Optional macro: WB_BYPASS_EN selects write-first register-file reads during
// a same-cycle writeback; when undefined, reads return the old value.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              InstrD,
  input  logic [XLEN-1:0]          PCD,
  input  logic [XLEN-1:0]          PCPlus4D,
  input  logic                     FlushE,
  input  logic                     RegWriteW,
  input  logic [$clog2(NREGS)-1:0] RdW,
  input  logic [XLEN-1:0]          ResultW,
  output logic [$clog2(NREGS)-1:0] Rs1D,
  output logic [$clog2(NREGS)-1:0] Rs2D,
  output logic [XLEN-1:0]          RD1E,
  output logic [XLEN-1:0]          RD2E,
  output logic [XLEN-1:0]          ImmExtE,
  output logic [$clog2(NREGS)-1:0] Rs1E,
  output logic [$clog2(NREGS)-1:0] Rs2E,
  output logic [$clog2(NREGS)-1:0] RdE,
  output logic [XLEN-1:0]          PCE,
  output logic [XLEN-1:0]          PCPlus4E,
  output logic                     RegWriteE,
  output logic                     MemWriteE,
  output logic                     ALUSrcE,
  output logic                     BranchE,
  output logic                     JumpE,
  output logic [1:0]               ResultSrcE,
  output logic [2:0]               ALUControlE
);

  localparam int RW = $clog2(NREGS);

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_J    = 3'd4
  } imm_sel_e;

  typedef struct packed {
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [RW-1:0]   rs1;
    logic [RW-1:0]   rs2;
    logic [RW-1:0]   rd;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            reg_write;
    logic            mem_write;
    logic            alu_src;
    logic            branch;
    logic            jump;
    logic [1:0]      result_src;
    logic [2:0]      alu_control;
  } idex_t;

  logic [XLEN-1:0] rf_q [NREGS];
  logic [XLEN-1:0] rf_d [NREGS];
  idex_t           idex_q;
  idex_t           idex_d;

  logic [6:0]      opcode_s;
  logic [2:0]      funct3_s;
  logic [RW-1:0]   rd_s;
  logic            reg_write_s;
  logic            mem_write_s;
  logic            alu_src_s;
  logic            branch_s;
  logic            jump_s;
  logic [1:0]      result_src_s;
  logic [1:0]      alu_op_s;
  imm_sel_e        imm_sel_s;
  logic [2:0]      alu_control_s;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] rd1_s;
  logic [XLEN-1:0] rd2_s;
  logic            wb_en_s;

  assign opcode_s = InstrD[6:0];
  assign funct3_s = InstrD[14:12];
  assign rd_s     = InstrD[11:7];
  assign Rs1D     = InstrD[19:15];
  assign Rs2D     = InstrD[24:20];
  assign wb_en_s  = RegWriteW && (RdW != {RW{1'b0}});

  // Main decoder: opcode to control bundle; unknown opcodes decode as NOP.
  always_comb begin
    reg_write_s  = 1'b0;
    mem_write_s  = 1'b0;
    alu_src_s    = 1'b0;
    branch_s     = 1'b0;
    jump_s       = 1'b0;
    result_src_s = 2'b00;
    alu_op_s     = 2'b00;
    imm_sel_s    = IMM_NONE;
    case (opcode_s)
      7'b0000011: begin reg_write_s = 1'b1; imm_sel_s = IMM_I; alu_src_s = 1'b1; result_src_s = 2'b01; end
      7'b0100011: begin imm_sel_s = IMM_S; alu_src_s = 1'b1; mem_write_s = 1'b1; end
      7'b0110011: begin reg_write_s = 1'b1; alu_op_s = 2'b10; end
      7'b0010011: begin reg_write_s = 1'b1; imm_sel_s = IMM_I; alu_src_s = 1'b1; alu_op_s = 2'b10; end
      7'b1100011: begin imm_sel_s = IMM_B; branch_s = 1'b1; alu_op_s = 2'b01; end
      7'b1101111: begin reg_write_s = 1'b1; imm_sel_s = IMM_J; result_src_s = 2'b10; jump_s = 1'b1; end
      default:    begin reg_write_s = 1'b0; end
    endcase
  end

  // ALU decoder: ALUOp plus funct3/funct7 to ALU operation code.
  always_comb begin
    alu_control_s = 3'b000;
    case (alu_op_s)
      2'b00: alu_control_s = 3'b000;
      2'b01: alu_control_s = 3'b001;
      2'b10: begin
        case (funct3_s)
          3'b000:  alu_control_s = (opcode_s[5] && InstrD[30]) ? 3'b001 : 3'b000;
          3'b010:  alu_control_s = 3'b101;
          3'b110:  alu_control_s = 3'b011;
          3'b111:  alu_control_s = 3'b010;
          default: alu_control_s = 3'b000;
        endcase
      end
      default: alu_control_s = 3'b000;
    endcase
  end

  // Immediate generator: sign-extended from InstrD[31]; zero when no immediate.
  always_comb begin
    imm_s = {XLEN{1'b0}};
    case (imm_sel_s)
      IMM_I:   imm_s = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
      IMM_S:   imm_s = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      IMM_B:   imm_s = {{(XLEN-13){InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
      IMM_J:   imm_s = {{(XLEN-21){InstrD[31]}}, InstrD[31], InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
      default: imm_s = {XLEN{1'b0}};
    endcase
  end

  // Register-file read ports; x0 is hardwired to zero.
  always_comb begin
    rd1_s = (Rs1D == {RW{1'b0}}) ? {XLEN{1'b0}} : rf_q[Rs1D];
    rd2_s = (Rs2D == {RW{1'b0}}) ? {XLEN{1'b0}} : rf_q[Rs2D];
`ifdef WB_BYPASS_EN
    if (wb_en_s && (RdW == Rs1D)) begin
      rd1_s = ResultW;
    end else begin
      rd1_s = rd1_s;
    end
    if (wb_en_s && (RdW == Rs2D)) begin
      rd2_s = ResultW;
    end else begin
      rd2_s = rd2_s;
    end
`endif
  end

  // Register-file next state: single write port, writes to x0 dropped.
  always_comb begin
    rf_d = rf_q;
    if (wb_en_s) begin
      rf_d[RdW] = ResultW;
    end else begin
      rf_d[RdW] = rf_q[RdW];
    end
  end

  // ID/EX next state: a flush loads an all-zero bubble over the new decode.
  always_comb begin
    idex_d = '0;
    if (FlushE) begin
      idex_d = '0;
    end else begin
      idex_d.rd1         = rd1_s;
      idex_d.rd2         = rd2_s;
      idex_d.imm         = imm_s;
      idex_d.rs1         = Rs1D;
      idex_d.rs2         = Rs2D;
      idex_d.rd          = rd_s;
      idex_d.pc          = PCD;
      idex_d.pc_plus4    = PCPlus4D;
      idex_d.reg_write   = reg_write_s;
      idex_d.mem_write   = mem_write_s;
      idex_d.alu_src     = alu_src_s;
      idex_d.branch      = branch_s;
      idex_d.jump        = jump_s;
      idex_d.result_src  = result_src_s;
      idex_d.alu_control = alu_control_s;
    end
  end

  // State registers: register file and ID/EX, both cleared by async reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_q   <= '{default: '0};
      idex_q <= '0;
    end else begin
      rf_q   <= rf_d;
      idex_q <= idex_d;
    end
  end

  assign RD1E        = idex_q.rd1;
  assign RD2E        = idex_q.rd2;
  assign ImmExtE     = idex_q.imm;
  assign Rs1E        = idex_q.rs1;
  assign Rs2E        = idex_q.rs2;
  assign RdE         = idex_q.rd;
  assign PCE         = idex_q.pc;
  assign PCPlus4E    = idex_q.pc_plus4;
  assign RegWriteE   = idex_q.reg_write;
  assign MemWriteE   = idex_q.mem_write;
  assign ALUSrcE     = idex_q.alu_src;
  assign BranchE     = idex_q.branch;
  assign JumpE       = idex_q.jump;
  assign ResultSrcE  = idex_q.result_src;
  assign ALUControlE = idex_q.alu_control;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage.
module tb_decode_stage;

  logic        clk;
  logic        rst;
  logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
  logic        FlushE, RegWriteW;
  logic [4:0]  RdW;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic        RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;

  int n_tests = 0;
  int n_fail  = 0;

  decode_stage dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .FlushE(FlushE), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE),
    .BranchE(BranchE), .JumpE(JumpE), .ResultSrcE(ResultSrcE),
    .ALUControlE(ALUControlE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [31:0] ins, input logic [31:0] pc);
    InstrD   = ins;
    PCD      = pc;
    PCPlus4D = pc + 32'd4;
  endtask

  task automatic wb(input logic en, input logic [4:0] rd, input logic [31:0] val);
    RegWriteW = en;
    RdW       = rd;
    ResultW   = val;
  endtask

  logic [31:0] all_ctl;

  initial begin
    rst = 1'b0;
    FlushE = 1'b0;
    wb(1'b0, 5'd0, 32'd0);
    set_instr(32'd0, 32'd0);

    // Reset held with random inputs.
    for (int i = 0; i < 3; i++) begin
      InstrD = $urandom; PCD = $urandom; PCPlus4D = $urandom;
      FlushE = 1'($urandom); RegWriteW = 1'($urandom);
      RdW = 5'($urandom); ResultW = $urandom;
      cycle();
    end
    all_ctl = {21'd0, RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE, ResultSrcE, ALUControlE};
    chk("rst_ctl", all_ctl, 32'd0);
    chk("rst_rd1", RD1E, 32'd0);
    chk("rst_imm", ImmExtE, 32'd0);
    chk("rst_pc", PCE | PCPlus4E, 32'd0);

    // Release reset; addi x0,x0,0.
    rst = 1'b1;
    FlushE = 1'b0;
    wb(1'b0, 5'd0, 32'd0);
    set_instr(32'h0000_0013, 32'h0000_0100);
    cycle();
    chk("nop_regwrite", {31'd0, RegWriteE}, 32'd1);
    chk("nop_rd", {27'd0, RdE}, 32'd0);
    chk("nop_imm", ImmExtE, 32'd0);
    chk("nop_aluctl", {29'd0, ALUControlE}, 32'd0);
    chk("nop_alusrc", {31'd0, ALUSrcE}, 32'd1);
    chk("nop_pc", PCE, 32'h0000_0100);
    chk("nop_pc4", PCPlus4E, 32'h0000_0104);

    // Writeback x5, then add x6,x5,x5.
    wb(1'b1, 5'd5, 32'hDEAD_BEEF);
    cycle();
    wb(1'b0, 5'd0, 32'd0);
    set_instr(32'h0052_8333, 32'h0000_0108);
    #1;
    chk("rs1d_comb", {27'd0, Rs1D}, 32'd5);
    chk("rs2d_comb", {27'd0, Rs2D}, 32'd5);
    cycle();
    chk("add_rd1", RD1E, 32'hDEAD_BEEF);
    chk("add_rd2", RD2E, 32'hDEAD_BEEF);
    chk("add_rd", {27'd0, RdE}, 32'd6);
    chk("add_alusrc", {31'd0, ALUSrcE}, 32'd0);
    chk("add_rs1e", {27'd0, Rs1E}, 32'd5);
    chk("add_imm", ImmExtE, 32'd0);

    // Write to x0 is discarded; add x9,x0,x0.
    wb(1'b1, 5'd0, 32'h0000_1234);
    set_instr(32'h0000_0013, 32'h0000_010C);
    cycle();
    wb(1'b0, 5'd0, 32'd0);
    set_instr(32'h0000_04B3, 32'h0000_0110);
    cycle();
    chk("x0_rd1", RD1E, 32'd0);
    chk("x0_rd2", RD2E, 32'd0);

    // lw x1,-4(x2)
    set_instr(32'hFFC1_2083, 32'h0000_0114);
    cycle();
    chk("lw_imm", ImmExtE, 32'hFFFF_FFFC);
    chk("lw_ressrc", {30'd0, ResultSrcE}, 32'd1);
    chk("lw_ctl", {27'd0, RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE}, 32'b10100);

    // beq x1,x2,-8
    set_instr(32'hFE20_8CE3, 32'h0000_0118);
    cycle();
    chk("beq_imm", ImmExtE, 32'hFFFF_FFF8);
    chk("beq_branch", {31'd0, BranchE}, 32'd1);
    chk("beq_aluctl", {29'd0, ALUControlE}, 32'd1);
    chk("beq_regwrite", {31'd0, RegWriteE}, 32'd0);

    // jal x1,+16
    set_instr(32'h0100_00EF, 32'h0000_011C);
    cycle();
    chk("jal_imm", ImmExtE, 32'h0000_0010);
    chk("jal_jump", {31'd0, JumpE}, 32'd1);
    chk("jal_ressrc", {30'd0, ResultSrcE}, 32'd2);
    chk("jal_pc4", PCPlus4E, 32'h0000_0120);

    // sw x2,4(x1) without flush
    set_instr(32'h0020_A223, 32'h0000_0120);
    cycle();
    chk("sw_memwrite", {31'd0, MemWriteE}, 32'd1);
    chk("sw_imm", ImmExtE, 32'h0000_0004);
    chk("sw_regwrite", {31'd0, RegWriteE}, 32'd0);

    // Same sw with FlushE: bubble.
    FlushE = 1'b1;
    set_instr(32'h0020_A223, 32'h0000_0124);
    cycle();
    FlushE = 1'b0;
    all_ctl = {21'd0, RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE, ResultSrcE, ALUControlE};
    chk("flush_ctl", all_ctl, 32'd0);
    chk("flush_imm", ImmExtE, 32'd0);
    chk("flush_pc", PCE, 32'd0);
    chk("flush_idx", {17'd0, Rs1E, Rs2E, RdE}, 32'd0);

    // ALU decoder coverage.
    set_instr(32'h4031_00B3, 32'h0000_0128); // sub x1,x2,x3
    cycle();
    chk("sub_aluctl", {29'd0, ALUControlE}, 32'd1);
    set_instr(32'hC000_0093, 32'h0000_012C); // addi x1,x0,-1024
    cycle();
    chk("addi_aluctl", {29'd0, ALUControlE}, 32'd0);
    chk("addi_imm", ImmExtE, 32'hFFFF_FC00);
    set_instr(32'h0050_6093, 32'h0000_0130); // ori x1,x0,5
    cycle();
    chk("ori_aluctl", {29'd0, ALUControlE}, 32'd3);
    set_instr(32'h0050_A093, 32'h0000_0134); // slti x1,x1,5
    cycle();
    chk("slti_aluctl", {29'd0, ALUControlE}, 32'd5);
    set_instr(32'h0FF0_7093, 32'h0000_0138); // andi x1,x0,0xFF
    cycle();
    chk("andi_aluctl", {29'd0, ALUControlE}, 32'd2);
    chk("andi_imm", ImmExtE, 32'h0000_00FF);

    // Same-cycle W/D collision on x7 (old value 0x11).
    wb(1'b1, 5'd7, 32'h0000_0011);
    set_instr(32'h0000_0013, 32'h0000_013C);
    cycle();
    wb(1'b1, 5'd7, 32'hA5A5_A5A5);
    set_instr(32'h0003_8433, 32'h0000_0140); // add x8,x7,x0
    cycle();
`ifdef WB_BYPASS_EN
    chk("collide_rd1", RD1E, 32'hA5A5_A5A5);
`else
    chk("collide_rd1", RD1E, 32'h0000_0011);
`endif
    wb(1'b0, 5'd0, 32'd0);
    cycle();
    chk("after_collide_rd1", RD1E, 32'hA5A5_A5A5);

    // Unknown opcode: controls zero, register read still happens.
    set_instr(32'h0003_807F, 32'h0000_0144);
    cycle();
    all_ctl = {21'd0, RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE, ResultSrcE, ALUControlE};
    chk("unk_ctl", all_ctl, 32'd0);
    chk("unk_rd1", RD1E, 32'hA5A5_A5A5);
    chk("unk_imm", ImmExtE, 32'd0);

    // Asynchronous reset mid-run clears outputs without a clock edge.
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_rd1", RD1E, 32'd0);
    chk("async_rst_pc", PCE, 32'd0);
    rst = 1'b1;
    set_instr(32'h0003_8433, 32'h0000_0148);
    cycle();
    chk("rf_cleared_x7", RD1E, 32'd0);
    chk("post_rst_regwrite", {31'd0, RegWriteE}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
